// File: rtl/ast_packer.sv
// Purpose: packs narrow Avalon-ST beats of one packet into wide words, first beat in the MS lane.
// Latency: one cycle from acceptance of the word-completing beat to ast_valid_o.
// Backpressure: ast_ready_o drops only while a word is held and the sink is stalled.
module ast_packer #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 256,
  parameter int EMPTY_IN_W  = $clog2(DATA_IN_W/8),
  parameter int EMPTY_OUT_W = $clog2(DATA_OUT_W/8),
  parameter int CHANNEL_W   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // sink side
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  // source side
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R        = DATA_OUT_W / DATA_IN_W;
  localparam int LANE_W   = $clog2(R);
  localparam int BYTES_IN = DATA_IN_W / 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state;
  logic [LANE_W-1:0]      lane;
  logic [DATA_OUT_W-1:0]  acc;
  logic                   acc_sop;
  logic [CHANNEL_W-1:0]   chan_q;

  logic                   accept;
  logic                   take;
  logic                   emit;
  logic [LANE_W-1:0]      eff_lane;
  logic                   eff_sop;
  logic [CHANNEL_W-1:0]   eff_chan;
  logic [LANE_W-1:0]      lanes_left;
  logic [EMPTY_OUT_W-1:0] empty_calc;
  logic [DATA_OUT_W-1:0]  merged;

  // The output register can always refill in the cycle it drains.
  assign ast_ready_o = !(ast_valid_o && !ast_ready_i);
  assign accept      = ast_valid_i && ast_ready_o;

  // A beat is used only if it opens a packet or continues one; sop always restarts at lane 0.
  assign take     = accept && (ast_startofpacket_i || state == ACCUM);
  assign eff_lane = ast_startofpacket_i ? '0 : lane;
  assign eff_sop  = ast_startofpacket_i || acc_sop;
  assign eff_chan = ast_startofpacket_i ? ast_channel_i : chan_q;
  assign emit     = take && (ast_endofpacket_i || eff_lane == LANE_W'(R-1));

  // Empty bytes = whole unused lanes after the eop beat plus the beat's own empty count.
  assign lanes_left = LANE_W'(R-1) - eff_lane;
  assign empty_calc = EMPTY_OUT_W'(lanes_left) * EMPTY_OUT_W'(BYTES_IN)
                    + EMPTY_OUT_W'(ast_empty_i);

  // Keep lanes already collected, drop in the new beat, zero every lane after it.
  always_comb begin
    merged = '0;
    for (int l = 0; l < R; l++) begin
      if (LANE_W'(l) < eff_lane) begin
        merged[DATA_OUT_W-1-l*DATA_IN_W -: DATA_IN_W] = acc[DATA_OUT_W-1-l*DATA_IN_W -: DATA_IN_W];
      end else if (LANE_W'(l) == eff_lane) begin
        merged[DATA_OUT_W-1-l*DATA_IN_W -: DATA_IN_W] = ast_data_i;
      end
    end
  end

  // Packing FSM with registered source outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= IDLE;
      lane                <= '0;
      acc                 <= '0;
      acc_sop             <= 1'b0;
      chan_q              <= '0;
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else begin
      if (take) begin
        acc <= merged;
        if (ast_startofpacket_i) begin
          chan_q <= ast_channel_i;
        end
        if (emit) begin
          lane    <= '0;
          acc_sop <= 1'b0;
          state   <= ast_endofpacket_i ? IDLE : ACCUM;
        end else begin
          lane    <= eff_lane + LANE_W'(1);
          acc_sop <= eff_sop;
          state   <= ACCUM;
        end
      end

      if (emit) begin
        ast_valid_o         <= 1'b1;
        ast_data_o          <= merged;
        ast_startofpacket_o <= eff_sop;
        ast_endofpacket_o   <= ast_endofpacket_i;
        ast_empty_o         <= ast_endofpacket_i ? empty_calc : '0;
        ast_channel_o       <= eff_chan;
      end else if (ast_ready_i) begin
        ast_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ast_packer.sv
// Purpose: self-checking bench for ast_packer; a beat-list model feeds an expected-word scoreboard.
// Latency: expects each word one cycle after its completing beat is accepted.
// Backpressure: drives ast_ready_i low in stall and random phases and checks held outputs stay stable.
module tb_ast_packer;

  localparam int DIW = 64;
  localparam int DOW = 256;
  localparam int R   = DOW / DIW;

  logic           clk_i;
  logic           rst_ni;
  logic [DIW-1:0] ast_data_i;
  logic           ast_startofpacket_i;
  logic           ast_endofpacket_i;
  logic           ast_valid_i;
  logic [2:0]     ast_empty_i;
  logic [9:0]     ast_channel_i;
  logic           ast_ready_o;
  logic [DOW-1:0] ast_data_o;
  logic           ast_startofpacket_o;
  logic           ast_endofpacket_o;
  logic           ast_valid_o;
  logic [4:0]     ast_empty_o;
  logic [9:0]     ast_channel_o;
  logic           ast_ready_i;

  ast_packer dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  typedef struct {
    logic [DOW-1:0] data;
    logic           sop;
    logic           eop;
    logic [4:0]     empty;
    logic [9:0]     chan;
  } word_t;

  word_t          exp_q[$];
  logic [DIW-1:0] beats[$];
  bit             in_pkt;
  bit             has_sop;
  logic [9:0]     m_chan;

  int n_cmp;
  int n_err;
  int n_acc;
  int n_words;

  bit             stalled;
  logic [DOW-1:0] snap_data;
  logic [16:0]    snap_ctrl;
  word_t          got;
  bit             rnd_run;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DOW-1:0] obs, input logic [DOW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: collect the beats of the current word, build it when full or at eop.
  task automatic model_beat(input logic [DIW-1:0] d, input logic s, input logic e,
                            input logic [2:0] emp, input logic [9:0] ch);
    word_t w;
    if (s) begin
      beats.delete();
      in_pkt  = 1;
      has_sop = 1;
      m_chan  = ch;
    end
    if (!in_pkt) return;
    beats.push_back(d);
    if (e || beats.size() == R) begin
      w.data = '0;
      foreach (beats[i]) w.data[DOW-1-DIW*i -: DIW] = beats[i];
      w.sop   = has_sop;
      w.eop   = e;
      w.empty = e ? 5'((R - beats.size()) * (DIW/8) + int'(emp)) : 5'd0;
      w.chan  = m_chan;
      exp_q.push_back(w);
      beats.delete();
      has_sop = 0;
      if (e) in_pkt = 0;
    end
  endtask

  // Monitor: compare drained words, check stability while stalled, feed accepted beats to the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (ast_valid_o) begin
        if (ast_ready_i) begin
          chk("sb_has_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("word_data", ast_data_o, got.data);
            chk("word_sop", ast_startofpacket_o, got.sop);
            chk("word_eop", ast_endofpacket_o, got.eop);
            chk("word_empty", ast_empty_o, got.empty);
            chk("word_chan", ast_channel_o, got.chan);
          end
          n_words++;
          stalled = 0;
        end else begin
          if (stalled) begin
            chk("stall_data", ast_data_o, snap_data);
            chk("stall_ctrl", {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, snap_ctrl);
            chk("stall_ready_o", ast_ready_o, 0);
          end
          stalled   = 1;
          snap_data = ast_data_o;
          snap_ctrl = {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
        end
      end else begin
        stalled = 0;
      end
      if (ast_valid_i && ast_ready_o) begin
        n_acc++;
        model_beat(ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i);
      end
    end
  end

  task automatic send(input logic [DIW-1:0] d, input logic s, input logic e,
                      input logic [2:0] emp, input logic [9:0] ch);
    bit acc;
    int budget;
    ast_data_i          = d;
    ast_startofpacket_i = s;
    ast_endofpacket_i   = e;
    ast_empty_i         = emp;
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    acc    = 0;
    budget = 0;
    while (!acc && budget < 200) begin
      @(negedge clk_i);
      acc = ast_ready_o;
      @(posedge clk_i);
      #1;
      budget++;
    end
    chk("send_accepted", acc, 1);
    ast_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] base, input logic [9:0] ch,
                          input logic [2:0] emp, input bit with_eop, input bit with_sop);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      send({8{b}}, with_sop && (i == 0), with_eop && (i == n-1), emp, ch);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || ast_valid_o) && i < 200) begin
      @(posedge clk_i);
      #1;
      i++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_ni = 1'b0;
    #1;
    chk({tag, "_valid_o"}, ast_valid_o, 0);
    chk({tag, "_ready_o"}, ast_ready_o, 1);
    chk({tag, "_data_o"}, ast_data_o, 0);
    chk({tag, "_sop_eop"}, {ast_startofpacket_o, ast_endofpacket_o}, 0);
    exp_q.delete();
    beats.delete();
    in_pkt  = 0;
    has_sop = 0;
    stalled = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int base_acc;
    int base_words;
    int len;
    n_cmp = 0; n_err = 0; n_acc = 0; n_words = 0;
    stalled = 0; in_pkt = 0; has_sop = 0; m_chan = '0; rnd_run = 0;
    rst_ni = 1'b0;
    ast_ready_i = 1'b1;
    ast_valid_i = 1'b0;
    ast_data_i = '0; ast_startofpacket_i = 0; ast_endofpacket_i = 0;
    ast_empty_i = '0; ast_channel_i = '0;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid_o", ast_valid_o, 0);
    chk("rst_ready_o", ast_ready_o, 1);
    chk("rst_data_o", ast_data_o, 0);
    chk("rst_ctrl", {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 4-beat packet, one full word, latency 1
    send({8{8'h11}}, 1, 0, 0, 10'd5);
    send({8{8'h22}}, 0, 0, 0, 10'd5);
    send({8{8'h33}}, 0, 0, 0, 10'd5);
    chk("t1_valid_before", ast_valid_o, 0);
    send({8{8'h44}}, 0, 1, 0, 10'd5);
    chk("t1_valid_lat1", ast_valid_o, 1);
    chk("t1_data", ast_data_o,
        256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444);
    chk("t1_sop_eop", {ast_startofpacket_o, ast_endofpacket_o}, 2'b11);
    chk("t1_empty", ast_empty_o, 0);
    chk("t1_chan", ast_channel_o, 5);
    idle(2);

    // 6-beat packet with empty 3 on eop
    send_pkt(5, 8'h21, 10'd9, 3'd0, 0, 1);
    send({8{8'h26}}, 0, 1, 3'd3, 10'd9);
    chk("t2_empty", ast_empty_o, 19);
    chk("t2_lanes23_zero", ast_data_o[127:0], 0);
    chk("t2_eop", ast_endofpacket_o, 1);
    idle(2);

    // single sop+eop beat with empty 7
    send({8{8'h5A}}, 1, 1, 3'd7, 10'd3);
    chk("t3_empty", ast_empty_o, 31);
    chk("t3_lanes123_zero", ast_data_o[191:0], 0);
    idle(2);

    // stall: 8 beats offered while the sink is stalled for 10 cycles
    base_acc   = n_acc;
    base_words = n_words;
    ast_ready_i = 1'b0;
    fork
      send_pkt(8, 8'hA0, 10'd7, 3'd2, 1, 1);
      begin
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("t4_accepted", n_acc - base_acc, 4);
        chk("t4_ready_o", ast_ready_o, 0);
        chk("t4_valid_o", ast_valid_o, 1);
        @(posedge clk_i);
        #1;
        ast_ready_i = 1'b1;
      end
    join
    wait_drain("t4_drain");
    chk("t4_words", n_words - base_words, 2);

    // non-sop beat in IDLE is dropped; sop at lane 2 restarts
    send({8{8'hEE}}, 0, 1, 3'd0, 10'd1);
    idle(3);
    chk("t5_no_out", ast_valid_o, 0);
    chk("t5_no_expected", exp_q.size(), 0);
    send_pkt(2, 8'hB0, 10'd3, 3'd0, 0, 1);
    send_pkt(4, 8'hC0, 10'd8, 3'd1, 1, 1);
    chk("t5_restart_data", ast_data_o,
        256'hC0C0C0C0C0C0C0C0_C1C1C1C1C1C1C1C1_C2C2C2C2C2C2C2C2_C3C3C3C3C3C3C3C3);
    chk("t5_restart_chan", ast_channel_o, 8);
    wait_drain("t5_drain");

    // reset with a partial word at lane 2; the tail must not produce output
    send_pkt(2, 8'h50, 10'd1, 3'd0, 0, 1);
    do_reset("r1");
    send_pkt(2, 8'h52, 10'd1, 3'd0, 1, 0);
    idle(3);
    chk("r1_no_stale", ast_valid_o, 0);

    // reset while a word is held under backpressure
    send_pkt(4, 8'h60, 10'd2, 3'd0, 0, 1);
    ast_ready_i = 1'b0;
    chk("r2_held_valid", ast_valid_o, 1);
    do_reset("r2");
    ast_ready_i = 1'b1;
    send({8{8'h64}}, 0, 1, 3'd0, 10'd2);
    idle(3);
    chk("r2_no_stale", ast_valid_o, 0);
    send_pkt(3, 8'h70, 10'd4, 3'd5, 1, 1);
    wait_drain("r2_drain");

    // random packets under random backpressure
    rnd_run = 1;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          if ($urandom_range(0, 4) == 0) send({8{8'hDD}}, 0, 0, 3'd0, 10'd0);
          len = $urandom_range(1, 9);
          for (int i = 0; i < len; i++) begin
            send({$urandom, $urandom}, i == 0, i == len-1, 3'($urandom_range(0, 7)),
                 10'($urandom_range(0, 1023)));
          end
        end
        rnd_run = 0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk_i);
          #1;
          ast_ready_i = ($urandom_range(0, 3) != 0);
        end
        ast_ready_i = 1'b1;
      end
    join
    wait_drain("rnd_drain");
    chk("model_idle", in_pkt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
